// File: rtl/com_bus_arbiter_if.sv
// Common-bus arbitration interface: request lines from proc/snoop/memory
// agents and the registered grants returned by com_bus_arbiter.
// master = requester side, slave = arbiter side.
interface com_bus_arbiter_if #(
  parameter int NUM_PROC  = 8,
  parameter int NUM_SNOOP = 4
);
  logic [NUM_PROC-1:0]  Com_Bus_Req_proc;
  logic [NUM_SNOOP-1:0] Com_Bus_Req_snoop;
  logic                 Mem_snoop_req;
  logic [NUM_PROC-1:0]  Com_Bus_Gnt_proc;
  logic [NUM_SNOOP-1:0] Com_Bus_Gnt_snoop_v;
  logic                 Com_Bus_Gnt_snoop;
  logic                 Mem_snoop_gnt;
  logic                 Timeout_err;

  modport master (
    output Com_Bus_Req_proc, Com_Bus_Req_snoop, Mem_snoop_req,
    input  Com_Bus_Gnt_proc, Com_Bus_Gnt_snoop_v, Com_Bus_Gnt_snoop,
           Mem_snoop_gnt, Timeout_err
  );

  modport slave (
    input  Com_Bus_Req_proc, Com_Bus_Req_snoop, Mem_snoop_req,
    output Com_Bus_Gnt_proc, Com_Bus_Gnt_snoop_v, Com_Bus_Gnt_snoop,
           Mem_snoop_gnt, Timeout_err
  );
endinterface

// File: rtl/com_bus_arbiter.sv
// com_bus_arbiter: common-bus arbiter for the MESI multiprocessor cache system.
// Round-robin bus ownership among processor-side cache controllers; while a
// proc owns the bus, the data phase goes round-robin to one snooping cache,
// or to memory when no cache snooper asks (a cache holding M supplies data).
// All grants are registered. Optional owner-hold timeout is enabled by
// defining ARB_TIMEOUT_EN; without it the bus is held indefinitely and
// Timeout_err is tied low.
module com_bus_arbiter #(
  parameter int NUM_PROC       = 8,
  parameter int NUM_SNOOP      = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic               clk,
  input  logic               rst,
  com_bus_arbiter_if.slave   bus
);

  localparam int PW = (NUM_PROC  > 1) ? $clog2(NUM_PROC)  : 1;
  localparam int SW = (NUM_SNOOP > 1) ? $clog2(NUM_SNOOP) : 1;
  localparam logic [NUM_PROC-1:0]  PROC_ONE = NUM_PROC'(1);
  localparam logic [NUM_SNOOP-1:0] SNP_ONE  = NUM_SNOOP'(1);

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("com_bus_arbiter: TIMEOUT_CYCLES must be >= 2");
  end

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PROC_OWN  = 2'd1,
    SNOOP_OWN = 2'd2,
    MEM_OWN   = 2'd3
  } state_t;

  state_t                r_state;
  logic [NUM_PROC-1:0]   r_gnt_proc;
  logic [NUM_SNOOP-1:0]  r_gnt_snp;
  logic                  r_mem_gnt;
  logic [PW-1:0]         r_proc_ptr;
  logic [SW-1:0]         r_snp_ptr;
  logic [PW-1:0]         r_owner;
  logic [SW-1:0]         r_snp_idx;

  logic                  w_proc_any;
  logic [PW-1:0]         w_proc_win;
  logic [PW-1:0]         w_proc_nxt;
  logic                  w_snp_any;
  logic [SW-1:0]         w_snp_win;
  logic [SW-1:0]         w_snp_nxt;
  logic                  w_owner_req;
  logic                  w_snp_req;
  logic                  w_timeout;

  // Proc round-robin pick: first requester at or after r_proc_ptr, wrapping.
  always_comb begin
    int w_idx;
    w_proc_any = 1'b0;
    w_proc_win = '0;
    w_idx      = 0;
    for (int k = 0; k < NUM_PROC; k++) begin
      w_idx = int'(r_proc_ptr) + k;
      if (w_idx >= NUM_PROC) w_idx = w_idx - NUM_PROC;
      if (!w_proc_any && bus.Com_Bus_Req_proc[PW'(w_idx)]) begin
        w_proc_any = 1'b1;
        w_proc_win = PW'(w_idx);
      end
    end
  end

  // Snooper round-robin pick, same rule with its own pointer.
  always_comb begin
    int w_idx;
    w_snp_any = 1'b0;
    w_snp_win = '0;
    w_idx     = 0;
    for (int k = 0; k < NUM_SNOOP; k++) begin
      w_idx = int'(r_snp_ptr) + k;
      if (w_idx >= NUM_SNOOP) w_idx = w_idx - NUM_SNOOP;
      if (!w_snp_any && bus.Com_Bus_Req_snoop[SW'(w_idx)]) begin
        w_snp_any = 1'b1;
        w_snp_win = SW'(w_idx);
      end
    end
  end

  // Pointer moves just past the winner so it goes to the back of the line.
  assign w_proc_nxt  = (w_proc_win == PW'(NUM_PROC - 1))  ? '0 : w_proc_win + 1'b1;
  assign w_snp_nxt   = (w_snp_win  == SW'(NUM_SNOOP - 1)) ? '0 : w_snp_win  + 1'b1;

  // Only the current owner's / granted snooper's request matters once granted.
  assign w_owner_req = bus.Com_Bus_Req_proc[r_owner];
  assign w_snp_req   = bus.Com_Bus_Req_snoop[r_snp_idx];

`ifdef ARB_TIMEOUT_EN
  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CW-1:0] r_cnt;
  logic          r_tmo_err;

  // Fires on the cycle the owner has already held the bus TIMEOUT_CYCLES cycles.
  assign w_timeout = (r_state != IDLE) && (r_cnt == CW'(TIMEOUT_CYCLES - 1));

  // Hold counter: zero while idle (so every fresh grant starts at 0), counts
  // every owned cycle including snoop/memory data phases of the same owner.
  always_ff @(posedge clk) begin
    if (rst)                             r_cnt <= '0;
    else if (r_state == IDLE || w_timeout) r_cnt <= '0;
    else                                 r_cnt <= r_cnt + 1'b1;
  end

  // Sticky timeout flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst)            r_tmo_err <= 1'b0;
    else if (w_timeout) r_tmo_err <= 1'b1;
  end

  assign bus.Timeout_err = r_tmo_err;
`else
  assign w_timeout       = 1'b0;
  assign bus.Timeout_err = 1'b0;
`endif

  // Arbitration FSM: owns every grant register and both RR pointers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_gnt_proc <= '0;
      r_gnt_snp  <= '0;
      r_mem_gnt  <= 1'b0;
      r_proc_ptr <= '0;
      r_snp_ptr  <= '0;
      r_owner    <= '0;
      r_snp_idx  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_gnt_proc <= '0;
          r_gnt_snp  <= '0;
          r_mem_gnt  <= 1'b0;
          if (w_proc_any) begin
            r_state    <= PROC_OWN;
            r_owner    <= w_proc_win;
            r_gnt_proc <= PROC_ONE << w_proc_win;
            r_proc_ptr <= w_proc_nxt;
          end
        end
        PROC_OWN: begin
          if (w_timeout || !w_owner_req) begin
            r_state    <= IDLE;
            r_gnt_proc <= '0;
            r_gnt_snp  <= '0;
            r_mem_gnt  <= 1'b0;
          end else if (w_snp_any) begin
            // Cache snoopers win over memory for the data phase.
            r_state   <= SNOOP_OWN;
            r_snp_idx <= w_snp_win;
            r_gnt_snp <= SNP_ONE << w_snp_win;
            r_snp_ptr <= w_snp_nxt;
          end else if (bus.Mem_snoop_req) begin
            r_state   <= MEM_OWN;
            r_mem_gnt <= 1'b1;
          end
        end
        SNOOP_OWN: begin
          if (w_timeout || !w_owner_req) begin
            // Owner abandoned the transaction: drop everything.
            r_state    <= IDLE;
            r_gnt_proc <= '0;
            r_gnt_snp  <= '0;
            r_mem_gnt  <= 1'b0;
          end else if (!w_snp_req) begin
            // Back through PROC_OWN so the next snooper waits at least a cycle.
            r_state   <= PROC_OWN;
            r_gnt_snp <= '0;
          end
        end
        MEM_OWN: begin
          if (w_timeout || !w_owner_req) begin
            r_state    <= IDLE;
            r_gnt_proc <= '0;
            r_gnt_snp  <= '0;
            r_mem_gnt  <= 1'b0;
          end else if (!bus.Mem_snoop_req) begin
            r_state   <= PROC_OWN;
            r_mem_gnt <= 1'b0;
          end
        end
        default: begin
          r_state    <= IDLE;
          r_gnt_proc <= '0;
          r_gnt_snp  <= '0;
          r_mem_gnt  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.Com_Bus_Gnt_proc    = r_gnt_proc;
  assign bus.Com_Bus_Gnt_snoop_v = r_gnt_snp;
  assign bus.Com_Bus_Gnt_snoop   = |r_gnt_snp;
  assign bus.Mem_snoop_gnt       = r_mem_gnt;

endmodule
